// File: rtl/pipeid_pkg.sv
// Shared ISA constants for the pipelined CPU: opcodes, functs, ALU codes and
// next-PC select encodings. Both ID and EX import this package.
package pipe_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  typedef enum logic [1:0] {
    PCSRC_PC4 = 2'b00,
    PCSRC_BPC = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_JPC = 2'b11
  } pcsrc_e;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/pipeid_if.sv
// Signal bundle around the ID stage: IF/ID inputs, EX/MEM/WB feedback and
// the decoded controls headed for pipedereg. No handshake; all levels.
interface pipeid_if;
  logic [31:0] i_inst;
  logic [7:0]  i_pc4;
  logic        i_ewreg, i_em2reg;
  logic [4:0]  i_ern;
  logic [31:0] i_ealu;
  logic        i_mwreg, i_mm2reg;
  logic [4:0]  i_mrn;
  logic [31:0] i_malu, i_mmo;
  logic        i_wwreg;
  logic [4:0]  i_wrn;
  logic [31:0] i_wdi;

  logic        o_wreg, o_m2reg, o_wmem, o_aluimm, o_shift, o_jal;
  logic [3:0]  o_aluc;
  logic [31:0] o_a, o_b, o_imm;
  logic [4:0]  o_rn, o_sa;
  logic [7:0]  o_pc4, o_bpc, o_jpc;
  logic [1:0]  o_pcsrc;
  logic        o_wpcir;

  // master is the surrounding pipeline, slave is the decode stage
  modport master (
    output i_inst, i_pc4, i_ewreg, i_em2reg, i_ern, i_ealu,
           i_mwreg, i_mm2reg, i_mrn, i_malu, i_mmo, i_wwreg, i_wrn, i_wdi,
    input  o_wreg, o_m2reg, o_wmem, o_aluimm, o_shift, o_jal, o_aluc,
           o_a, o_b, o_imm, o_rn, o_sa, o_pc4, o_bpc, o_jpc, o_pcsrc, o_wpcir
  );

  modport slave (
    input  i_inst, i_pc4, i_ewreg, i_em2reg, i_ern, i_ealu,
           i_mwreg, i_mm2reg, i_mrn, i_malu, i_mmo, i_wwreg, i_wrn, i_wdi,
    output o_wreg, o_m2reg, o_wmem, o_aluimm, o_shift, o_jal, o_aluc,
           o_a, o_b, o_imm, o_rn, o_sa, o_pc4, o_bpc, o_jpc, o_pcsrc, o_wpcir
  );
endinterface

// File: rtl/pipeid_regfile.sv
// 32x32 register file: two combinational read ports with WB write-through,
// one synchronous write port. r0 is hardwired to zero.
module pipe_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];
  logic        wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Write-through lets ID see the WB result in the cycle it is written.
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (wr_en && wa == ra1) rd1 = wd;
    if (wr_en && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/pipeid.sv
// Instruction-decode stage: control decode, register file, EX/MEM operand
// forwarding, load-use bubble insertion and branch/jump resolution.
module pipeid
  import pipe_defs::*;
(
  input  logic     clk,
  input  logic     rst,
  pipeid_if.slave  bus
);

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic        r_type;
  logic        i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic        i_addi, i_andi, i_ori, i_xori, i_lw, i_sw;
  logic        i_beq, i_bne, i_lui, i_j, i_jal;
  logic        dec_wreg, uses_rs, uses_rt, stall, zero_ext;
  logic [3:0]  aluc;
  logic [31:0] imm, rf_a, rf_b, fwd_a, fwd_b;
  pcsrc_e      pcsrc;

  assign op = bus.i_inst[31:26];
  assign rs = bus.i_inst[25:21];
  assign rt = bus.i_inst[20:16];
  assign rd = bus.i_inst[15:11];
  assign fn = bus.i_inst[5:0];

  assign r_type = (op == OP_RTYPE);
  assign i_add  = r_type && fn == FN_ADD;
  assign i_sub  = r_type && fn == FN_SUB;
  assign i_and  = r_type && fn == FN_AND;
  assign i_or   = r_type && fn == FN_OR;
  assign i_xor  = r_type && fn == FN_XOR;
  assign i_sll  = r_type && fn == FN_SLL;
  assign i_srl  = r_type && fn == FN_SRL;
  assign i_sra  = r_type && fn == FN_SRA;
  assign i_jr   = r_type && fn == FN_JR;
  assign i_addi = (op == OP_ADDI);
  assign i_andi = (op == OP_ANDI);
  assign i_ori  = (op == OP_ORI);
  assign i_xori = (op == OP_XORI);
  assign i_lw   = (op == OP_LW);
  assign i_sw   = (op == OP_SW);
  assign i_beq  = (op == OP_BEQ);
  assign i_bne  = (op == OP_BNE);
  assign i_lui  = (op == OP_LUI);
  assign i_j    = (op == OP_J);
  assign i_jal  = (op == OP_JAL);

  assign dec_wreg = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                    i_addi | i_andi | i_ori | i_xori | i_lw | i_lui | i_jal;

  // Operand usage drives the load-use check; shifts take rt only.
  assign uses_rs = i_add | i_sub | i_and | i_or | i_xor | i_jr |
                   i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne;
  assign uses_rt = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                   i_jr | i_sw | i_beq | i_bne;

  assign stall = bus.i_ewreg && bus.i_em2reg && (bus.i_ern != 5'd0) &&
                 ((uses_rs && bus.i_ern == rs) || (uses_rt && bus.i_ern == rt));

  always_comb begin
    aluc = ALU_ADD;
    if (i_sub | i_beq | i_bne)      aluc = ALU_SUB;
    else if (i_and | i_andi)        aluc = ALU_AND;
    else if (i_or | i_ori)          aluc = ALU_OR;
    else if (i_xor | i_xori)        aluc = ALU_XOR;
    else if (i_lui)                 aluc = ALU_LUI;
    else if (i_sll)                 aluc = ALU_SLL;
    else if (i_srl)                 aluc = ALU_SRL;
    else if (i_sra)                 aluc = ALU_SRA;
  end

  assign zero_ext = i_andi | i_ori | i_xori;
  assign imm = zero_ext ? {16'b0, bus.i_inst[15:0]}
                        : {{16{bus.i_inst[15]}}, bus.i_inst[15:0]};

  pipe_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_a),
    .rd2 (rf_b),
    .we  (bus.i_wwreg),
    .wa  (bus.i_wrn),
    .wd  (bus.i_wdi)
  );

  // EX beats MEM; a load still in EX cannot forward and is handled by stall.
  function automatic logic [31:0] forward(input logic [4:0] src, input logic [31:0] rf_val);
    logic [31:0] val;
    val = rf_val;
    if (bus.i_ewreg && !bus.i_em2reg && bus.i_ern == src && src != 5'd0)
      val = bus.i_ealu;
    else if (bus.i_mwreg && bus.i_mrn == src && src != 5'd0)
      val = bus.i_mm2reg ? bus.i_mmo : bus.i_malu;
    return val;
  endfunction

  assign fwd_a = forward(rs, rf_a);
  assign fwd_b = forward(rt, rf_b);

  always_comb begin
    pcsrc = PCSRC_PC4;
    if (i_jr)                                     pcsrc = PCSRC_JR;
    else if (i_j | i_jal)                         pcsrc = PCSRC_JPC;
    else if ((i_beq && fwd_a == fwd_b) ||
             (i_bne && fwd_a != fwd_b))           pcsrc = PCSRC_BPC;
    if (stall || rst)                             pcsrc = PCSRC_PC4;
  end

  assign bus.o_wreg   = dec_wreg && !stall && !rst;
  assign bus.o_wmem   = i_sw && !stall && !rst;
  assign bus.o_m2reg  = i_lw && !rst;
  assign bus.o_jal    = i_jal && !rst;
  assign bus.o_shift  = (i_sll | i_srl | i_sra) && !rst;
  assign bus.o_aluimm = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
  assign bus.o_aluc   = aluc;
  assign bus.o_a      = rst ? 32'd0 : fwd_a;
  assign bus.o_b      = rst ? 32'd0 : fwd_b;
  assign bus.o_imm    = rst ? 32'd0 : imm;
  assign bus.o_rn     = i_jal ? REG_RA : (r_type ? rd : rt);
  assign bus.o_sa     = bus.i_inst[10:6];
  assign bus.o_pc4    = bus.i_pc4;
  assign bus.o_bpc    = bus.i_pc4 + {bus.i_inst[5:0], 2'b00};
  assign bus.o_jpc    = {bus.i_inst[5:0], 2'b00};
  assign bus.o_pcsrc  = pcsrc;
  assign bus.o_wpcir  = rst || !stall;

endmodule

// File: tb/tb_pipeid.sv
// Self-checking bench for the ID stage: expected values queued as stimulus is
// driven, popped and compared once the combinational outputs settle.
module tb_pipeid;
  import pipe_defs::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeid_if bus ();
  pipeid dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] model_rf [32];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    if (exp_q.size() == 0) check_val("sb_empty", 32'd1, 32'd0);
    else check_val(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive_idle();
    bus.i_inst = 32'hFC00_0000; bus.i_pc4 = 8'h0;
    bus.i_ewreg = 0; bus.i_em2reg = 0; bus.i_ern = 0; bus.i_ealu = 0;
    bus.i_mwreg = 0; bus.i_mm2reg = 0; bus.i_mrn = 0; bus.i_malu = 0; bus.i_mmo = 0;
    bus.i_wwreg = 0; bus.i_wrn = 0; bus.i_wdi = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    int r;
    logic [31:0] d;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    rst = 1'b1;
    drive_idle();
    bus.i_inst = enc_r(5'd5, 5'd0, 5'd9, FN_ADD);
    tick(); tick();

    // reset state
    expect_val("rst_wpcir", 32'd1); expect_val("rst_wreg", 32'd0);
    expect_val("rst_a", 32'd0);     expect_val("rst_pcsrc", 32'd0);
    settle();
    observe(bus.o_wpcir); observe(bus.o_wreg); observe(bus.o_a); observe(bus.o_pcsrc);

    rst = 1'b0;
    expect_val("r5_a", 32'd0); expect_val("add_wreg", 32'd1); expect_val("add_rn", 32'd9);
    settle();
    observe(bus.o_a); observe(bus.o_wreg); observe(bus.o_rn);

    // WB write-through then persistence
    tick();
    bus.i_inst = enc_r(5'd8, 5'd0, 5'd9, FN_ADD);
    bus.i_wwreg = 1; bus.i_wrn = 5'd8; bus.i_wdi = 32'h1234_5678;
    expect_val("wt_a", 32'h1234_5678);
    settle(); observe(bus.o_a);
    tick(); model_rf[8] = 32'h1234_5678;
    bus.i_wwreg = 0;
    expect_val("persist_a", model_rf[8]);
    settle(); observe(bus.o_a);

    // r0 write ignored
    bus.i_inst = enc_r(5'd0, 5'd0, 5'd9, FN_ADD);
    bus.i_wwreg = 1; bus.i_wrn = 5'd0; bus.i_wdi = 32'hFFFF_FFFF;
    expect_val("r0_wt", 32'd0); settle(); observe(bus.o_a);
    tick(); bus.i_wwreg = 0;
    expect_val("r0_after", 32'd0); settle(); observe(bus.o_a);

    // forwarding priority
    bus.i_inst = enc_r(5'd4, 5'd0, 5'd1, FN_ADD);
    bus.i_ewreg = 1; bus.i_ern = 5'd4; bus.i_ealu = 32'hA;
    bus.i_mwreg = 1; bus.i_mrn = 5'd4; bus.i_malu = 32'hB; bus.i_mmo = 32'hC;
    expect_val("fwd_ex", 32'hA); settle(); observe(bus.o_a);
    bus.i_ewreg = 0;
    expect_val("fwd_mem_alu", 32'hB); settle(); observe(bus.o_a);
    bus.i_mm2reg = 1;
    expect_val("fwd_mem_mo", 32'hC); settle(); observe(bus.o_a);
    bus.i_inst = enc_r(5'd0, 5'd4, 5'd1, FN_ADD);
    expect_val("fwd_rt", 32'hC); settle(); observe(bus.o_b);
    drive_idle();

    // load-use stall
    bus.i_ewreg = 1; bus.i_em2reg = 1; bus.i_ern = 5'd3;
    bus.i_inst = enc_r(5'd3, 5'd2, 5'd1, FN_SUB);
    expect_val("lu_wpcir", 32'd0); expect_val("lu_wreg", 32'd0);
    settle(); observe(bus.o_wpcir); observe(bus.o_wreg);
    bus.i_inst = enc_i(OP_SW, 5'd0, 5'd3, 16'd4);
    expect_val("lu_sw_wmem", 32'd0); expect_val("lu_sw_wpcir", 32'd0);
    settle(); observe(bus.o_wmem); observe(bus.o_wpcir);
    bus.i_inst = enc_i(OP_LUI, 5'd0, 5'd3, 16'd1);
    expect_val("lui_wpcir", 32'd1); expect_val("lui_wreg", 32'd1);
    expect_val("lui_aluc", {28'd0, ALU_LUI}); expect_val("lui_imm", 32'd1);
    settle(); observe(bus.o_wpcir); observe(bus.o_wreg); observe(bus.o_aluc); observe(bus.o_imm);
    bus.i_inst = enc_i(OP_BEQ, 5'd3, 5'd3, 16'hFFFE);
    expect_val("stall_beats_br", 32'd0); settle(); observe(bus.o_pcsrc);
    drive_idle();

    // immediate extension and shifts
    bus.i_inst = enc_i(OP_ANDI, 5'd0, 5'd2, 16'h8000);
    expect_val("andi_imm", 32'h0000_8000); expect_val("andi_aluc", {28'd0, ALU_AND});
    settle(); observe(bus.o_imm); observe(bus.o_aluc);
    bus.i_inst = enc_i(OP_ADDI, 5'd0, 5'd2, 16'h8000);
    expect_val("addi_imm", 32'hFFFF_8000); expect_val("addi_rn", 32'd2);
    settle(); observe(bus.o_imm); observe(bus.o_rn);
    bus.i_inst = {OP_RTYPE, 5'd0, 5'd8, 5'd7, 5'd3, FN_SRA};
    expect_val("sra_shift", 32'd1); expect_val("sra_aluc", {28'd0, ALU_SRA});
    expect_val("sra_sa", 32'd3);
    settle(); observe(bus.o_shift); observe(bus.o_aluc); observe(bus.o_sa);

    // branches
    bus.i_pc4 = 8'h10;
    bus.i_inst = enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFE);
    expect_val("beq_bpc", 32'h08); expect_val("beq_taken", 32'd1);
    settle(); observe(bus.o_bpc); observe(bus.o_pcsrc);
    bus.i_inst = enc_i(OP_BEQ, 5'd8, 5'd0, 16'hFFFE);
    expect_val("beq_not", 32'd0); settle(); observe(bus.o_pcsrc);
    bus.i_inst = enc_i(OP_BNE, 5'd8, 5'd0, 16'hFFFE);
    expect_val("bne_taken", 32'd1); settle(); observe(bus.o_pcsrc);
    bus.i_inst = enc_i(OP_BNE, 5'd0, 5'd0, 16'hFFFE);
    expect_val("bne_not", 32'd0); settle(); observe(bus.o_pcsrc);

    // jumps
    bus.i_inst = {OP_JAL, 26'h5};
    expect_val("jal_jpc", 32'h14); expect_val("jal_pcsrc", 32'd3);
    expect_val("jal_rn", 32'd31); expect_val("jal_flag", 32'd1);
    settle(); observe(bus.o_jpc); observe(bus.o_pcsrc); observe(bus.o_rn); observe(bus.o_jal);
    bus.i_wwreg = 1; bus.i_wrn = 5'd31; bus.i_wdi = 32'h40;
    tick(); model_rf[31] = 32'h40; bus.i_wwreg = 0;
    bus.i_inst = enc_r(5'd31, 5'd0, 5'd0, FN_JR);
    expect_val("jr_pcsrc", 32'd2); expect_val("jr_a", model_rf[31]); expect_val("jr_wreg", 32'd0);
    settle(); observe(bus.o_pcsrc); observe(bus.o_a); observe(bus.o_wreg);

    // random register writes against a reference copy
    for (int k = 0; k < 8; k++) begin
      tick();
      r = $urandom_range(1, 31);
      d = $urandom;
      bus.i_inst = enc_r(5'd0, r[4:0], 5'd1, FN_OR);
      bus.i_wwreg = 1; bus.i_wrn = r[4:0]; bus.i_wdi = d;
      expect_val("rnd_wt", d); settle(); observe(bus.o_b);
      tick(); model_rf[r] = d; bus.i_wwreg = 0;
      bus.i_inst = enc_r(r[4:0], 5'd0, 5'd1, FN_OR);
      expect_val("rnd_rd", model_rf[r]); settle(); observe(bus.o_a);
    end

    check_val("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
